// File: rtl/abro_pkg.sv
// abro_pkg
// Shared definitions for the ABRO family of join controllers.
// Holds the FSM state encoding used by both the two-input ABRO block and
// the parametrised abro_join block.
package abro_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  // Waiting for events to arrive in the current round.
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd0;
  // Round completed, holding until restart.
  localparam logic [STATE_W-1:0] ST_DONE = 2'd1;

endpackage : abro_pkg

// File: rtl/abro_timeout_ctr.sv
// abro_timeout_ctr
// Inactivity counter for abro_join. Counts enabled cycles and flags the
// cycle in which the count has reached TIMEOUT-1.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   clr    - synchronous clear, wins over en
//   en     - advance the count by one
//   expire - count equals TIMEOUT-1 (constant 0 when TIMEOUT is 0)
module abro_timeout_ctr #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_s;
      assign unused_s = ^{clk, resetn, clr, en};
      assign expire   = 1'b0;
    end else begin : g_on
      localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Next count: clear dominates, otherwise step when enabled.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = {CW{1'b0}};
        end else if (en) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Count register.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_q <= {CW{1'b0}};
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // The owner clears the count on expiry, so it never reaches TIMEOUT.
      assign expire = (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule : abro_timeout_ctr

// File: rtl/abro_join.sv
// abro_join
// Waits until every one of N_EVENTS event strobes has fired at least once
// (any order, any spacing), then emits a one-cycle completion pulse.
// Optional auto-rearm and optional inactivity timeout.
// Ports:
//   clk     - rising-edge clock
//   resetn  - asynchronous active-low reset
//   ev      - event strobes, level-sampled each edge
//   r       - synchronous restart/abort, highest synchronous priority
//   o       - completion pulse (registered, one cycle)
//   timeout - timeout pulse (registered, one cycle)
//   seen    - events captured in the current round
//   state   - current FSM state
module abro_join
  import abro_pkg::*;
#(
  parameter int N_EVENTS = 2,
  parameter int REARM    = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_EVENTS-1:0] ev,
  input  logic                r,
  output logic                o,
  output logic                timeout,
  output logic [N_EVENTS-1:0] seen,
  output logic [STATE_W-1:0]  state
);

  state_t              state_q, state_d;
  logic [N_EVENTS-1:0] seen_q, seen_d;
  logic                o_q, o_d;
  logic                timeout_q, timeout_d;
  logic                all_s;
  logic                ctr_clr_s;
  logic                ctr_en_s;
  logic                expire_s;

  assign all_s = &(seen_q | ev);

  abro_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .resetn(resetn),
    .clr   (ctr_clr_s),
    .en    (ctr_en_s),
    .expire(expire_s)
  );

  // Next-state, seen, pulse and counter-control decode.
  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    o_d       = 1'b0;
    timeout_d = 1'b0;
    ctr_clr_s = 1'b0;
    ctr_en_s  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (r) begin
          seen_d    = {N_EVENTS{1'b0}};
          ctr_clr_s = 1'b1;
        end else if (all_s && !o_q) begin
          // o_q is only high here in rearm mode: the edge right after a
          // completion always captures into the fresh round instead of
          // completing again, so held-high events give 2-cycle spacing.
          o_d       = 1'b1;
          ctr_clr_s = 1'b1;
          if (REARM != 0) begin
            seen_d = {N_EVENTS{1'b0}};
          end else begin
            state_d = ST_DONE;
            seen_d  = {N_EVENTS{1'b1}};
          end
        end else if (expire_s && (seen_q != {N_EVENTS{1'b0}})) begin
          // Events arriving on the expiry edge are dropped on purpose.
          timeout_d = 1'b1;
          seen_d    = {N_EVENTS{1'b0}};
          ctr_clr_s = 1'b1;
        end else begin
          seen_d   = seen_q | ev;
          // Countdown starts only once the first event has been captured.
          ctr_en_s = (seen_q != {N_EVENTS{1'b0}});
        end
      end
      ST_DONE: begin
        ctr_clr_s = 1'b1;
        if (r) begin
          state_d = ST_WAIT;
          seen_d  = {N_EVENTS{1'b0}};
        end else begin
          seen_d  = {N_EVENTS{1'b1}};
        end
      end
      default: begin
        state_d   = ST_WAIT;
        seen_d    = {N_EVENTS{1'b0}};
        ctr_clr_s = 1'b1;
      end
    endcase
  end

  // State, seen and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_WAIT;
      seen_q    <= {N_EVENTS{1'b0}};
      o_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      o_q       <= o_d;
      timeout_q <= timeout_d;
    end
  end

  assign o       = o_q;
  assign timeout = timeout_q;
  assign seen    = seen_q;
  assign state   = state_q;

endmodule : abro_join

// File: tb/tb_abro_join.sv
// tb_abro_join
// Directed bench for abro_join with three configurations:
//   a: N=2, REARM=0, TIMEOUT=0
//   b: N=4, REARM=1, TIMEOUT=0
//   c: N=3, REARM=0, TIMEOUT=5
module tb_abro_join;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;

  logic [1:0] a_ev = 2'b00;
  logic       a_r = 1'b0;
  logic       a_o, a_to;
  logic [1:0] a_seen, a_state;

  logic [3:0] b_ev = 4'b0000;
  logic       b_r = 1'b0;
  logic       b_o, b_to;
  logic [3:0] b_seen;
  logic [1:0] b_state;

  logic [2:0] c_ev = 3'b000;
  logic       c_r = 1'b0;
  logic       c_o, c_to;
  logic [2:0] c_seen;
  logic [1:0] c_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  abro_join #(.N_EVENTS(2), .REARM(0), .TIMEOUT(0)) dut_a (
    .clk(clk), .resetn(resetn), .ev(a_ev), .r(a_r),
    .o(a_o), .timeout(a_to), .seen(a_seen), .state(a_state)
  );

  abro_join #(.N_EVENTS(4), .REARM(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .resetn(resetn), .ev(b_ev), .r(b_r),
    .o(b_o), .timeout(b_to), .seen(b_seen), .state(b_state)
  );

  abro_join #(.N_EVENTS(3), .REARM(0), .TIMEOUT(5)) dut_c (
    .clk(clk), .resetn(resetn), .ev(c_ev), .r(c_r),
    .o(c_o), .timeout(c_to), .seen(c_seen), .state(c_state)
  );

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({a_o, a_to, a_seen, a_state} !== 6'd0) begin
      errors++;
      $display("FAIL reset_a: got %b expected 000000", {a_o, a_to, a_seen, a_state});
    end
    checks++;
    if ({b_o, b_to, b_seen, b_state} !== 8'd0) begin
      errors++;
      $display("FAIL reset_b: got %b expected 00000000", {b_o, b_to, b_seen, b_state});
    end
    checks++;
    if ({c_o, c_to, c_seen, c_state} !== 7'd0) begin
      errors++;
      $display("FAIL reset_c: got %b expected 0000000", {c_o, c_to, c_seen, c_state});
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic_join();
    a_ev = 2'b01;
    step();
    checks++;
    if ({a_o, a_seen, a_state} !== {1'b0, 2'b01, 2'd0}) begin
      errors++;
      $display("FAIL join_first: got o=%b seen=%b st=%0d expected o=0 seen=01 st=0", a_o, a_seen, a_state);
    end
    a_ev = 2'b00;
    step();
    step();
    a_ev = 2'b10;
    step();
    checks++;
    if ({a_o, a_seen, a_state} !== {1'b1, 2'b11, 2'd1}) begin
      errors++;
      $display("FAIL join_done: got o=%b seen=%b st=%0d expected o=1 seen=11 st=1", a_o, a_seen, a_state);
    end
    a_ev = 2'b00;
    step();
    checks++;
    if ({a_o, a_state} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL join_pulse_width: got o=%b st=%0d expected o=0 st=1", a_o, a_state);
    end
    a_ev = 2'b11;
    step();
    checks++;
    if ({a_o, a_to, a_seen, a_state} !== {1'b0, 1'b0, 2'b11, 2'd1}) begin
      errors++;
      $display("FAIL done_ignores_ev: got o=%b to=%b seen=%b st=%0d expected o=0 to=0 seen=11 st=1", a_o, a_to, a_seen, a_state);
    end
    a_ev = 2'b00;
    a_r = 1'b1;
    step();
    a_r = 1'b0;
    checks++;
    if ({a_o, a_seen, a_state} !== {1'b0, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL restart_from_done: got o=%b seen=%b st=%0d expected o=0 seen=00 st=0", a_o, a_seen, a_state);
    end
  endtask

  task automatic test_same_edge();
    a_ev = 2'b11;
    step();
    a_ev = 2'b00;
    checks++;
    if ({a_o, a_seen, a_state} !== {1'b1, 2'b11, 2'd1}) begin
      errors++;
      $display("FAIL single_cycle_join: got o=%b seen=%b st=%0d expected o=1 seen=11 st=1", a_o, a_seen, a_state);
    end
    a_r = 1'b1;
    step();
    a_ev = 2'b11;
    step();
    a_ev = 2'b00;
    a_r = 1'b0;
    checks++;
    if ({a_o, a_seen, a_state} !== {1'b0, 2'b00, 2'd0}) begin
      errors++;
      $display("FAIL restart_beats_join: got o=%b seen=%b st=%0d expected o=0 seen=00 st=0", a_o, a_seen, a_state);
    end
    step();
    checks++;
    if (a_o !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_late_o: got o=%b expected 0", a_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_o;
    logic [3:0] exp_seen [6];
    exp_o = 6'b010101;
    exp_seen = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    b_ev = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({b_o, b_seen, b_state} !== {exp_o[i], exp_seen[i], 2'd0}) begin
        errors++;
        $display("FAIL rearm_cycle%0d: got o=%b seen=%b st=%0d expected o=%b seen=%b st=0", i, b_o, b_seen, b_state, exp_o[i], exp_seen[i]);
      end
    end
    b_ev = 4'b0000;
    step();
    checks++;
    if ({b_o, b_seen} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL rearm_tail: got o=%b seen=%b expected o=1 seen=0000", b_o, b_seen);
    end
    step();
    checks++;
    if ({b_o, b_seen} !== {1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL rearm_idle: got o=%b seen=%b expected o=0 seen=0000", b_o, b_seen);
    end
  endtask

  task automatic test_timeout();
    c_ev = 3'b001;
    step();
    c_ev = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({c_to, c_seen} !== {1'b0, 3'b001}) begin
        errors++;
        $display("FAIL timeout_early_e+%0d: got to=%b seen=%b expected to=0 seen=001", i, c_to, c_seen);
      end
    end
    step();
    checks++;
    if ({c_o, c_to, c_seen, c_state} !== {1'b0, 1'b1, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL timeout_fire: got o=%b to=%b seen=%b st=%0d expected o=0 to=1 seen=000 st=0", c_o, c_to, c_seen, c_state);
    end
    step();
    checks++;
    if (c_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: got to=%b expected 0", c_to);
    end
    c_ev = 3'b001;
    step();
    c_ev = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      step();
    end
    c_ev = 3'b110;
    step();
    c_ev = 3'b000;
    checks++;
    if ({c_o, c_to, c_seen, c_state} !== {1'b1, 1'b0, 3'b111, 2'd1}) begin
      errors++;
      $display("FAIL complete_beats_timeout: got o=%b to=%b seen=%b st=%0d expected o=1 to=0 seen=111 st=1", c_o, c_to, c_seen, c_state);
    end
    for (int i = 0; i < 6; i++) begin
      step();
    end
    checks++;
    if ({c_o, c_to, c_state} !== {1'b0, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL done_no_timeout: got o=%b to=%b st=%0d expected o=0 to=0 st=1", c_o, c_to, c_state);
    end
    c_r = 1'b1;
    step();
    c_r = 1'b0;
    checks++;
    if ({c_seen, c_state} !== {3'b000, 2'd0}) begin
      errors++;
      $display("FAIL timeout_restart: got seen=%b st=%0d expected seen=000 st=0", c_seen, c_state);
    end
  endtask

  task automatic test_async_reset();
    c_ev = 3'b011;
    step();
    c_ev = 3'b000;
    checks++;
    if (c_seen !== 3'b011) begin
      errors++;
      $display("FAIL pre_reset_seen: got %b expected 011", c_seen);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({c_o, c_to, c_seen, c_state} !== {1'b0, 1'b0, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: got o=%b to=%b seen=%b st=%0d expected all 0", c_o, c_to, c_seen, c_state);
    end
    #1;
    resetn = 1'b1;
    step();
    c_ev = 3'b100;
    step();
    c_ev = 3'b000;
    checks++;
    if ({c_o, c_seen} !== {1'b0, 3'b100}) begin
      errors++;
      $display("FAIL post_reset_no_o: got o=%b seen=%b expected o=0 seen=100", c_o, c_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic_join();
    test_same_edge();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_abro_join
